// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: the CPU memory stage owns the bus by default;
// an auxiliary master (DMA / boot loader) takes idle slots, is force-granted
// after STARVE_LIMIT consecutive denials, and may lock the bus for bursts of
// up to MAX_LOCK granted cycles. The slave is combinational, so bus outputs
// and read data are routed in the same cycle as the request.
//
// Optional feature macro: DATA_BUS_ARB_STATS_EN
//   defined   -> stat_cpu_stalls / stat_aux_xfers are saturating 32-bit counters
//   undefined -> both stat ports tied to 0, no counter logic
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   cpu_re/we/addr/wdata -> cpu_rdata   CPU request / read data
//   cpu_stall                           CPU access held off this cycle
//   aux_req/lock/we/addr/wdata          aux request, burst lock, payload
//   aux_gnt, aux_rdata                  aux transfer performed / read data
//   bus_re/we/addr/wdata <- bus_rdata   shared slave port
//   stat_cpu_stalls, stat_aux_xfers     statistics counters
module data_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned MAX_LOCK     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_re,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        aux_req,
    input  logic        aux_lock,
    input  logic [3:0]  aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    output logic        aux_gnt,
    output logic [31:0] aux_rdata,
    output logic        bus_re,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic [31:0] stat_cpu_stalls,
    output logic [31:0] stat_aux_xfers
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(MAX_LOCK - 1);
    // A one-cycle burst limit is already met by the entry grant, so no lock state is needed.
    localparam bit LOCK_ALLOWED = (MAX_LOCK > 1);

    typedef enum logic [1:0] {
        S_CPU   = 2'd0,
        S_FORCE = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_nxt;
    logic             cpu_act;
    logic             aux_rd;
    logic             sel_cpu;
    logic             sel_aux;
    logic             stall;

    assign cpu_act = cpu_re | (|cpu_we);
    assign aux_rd  = (aux_we == 4'd0);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_CPU;
            wait_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            lock_cnt <= lock_nxt;
        end
    end

    // Ownership decision, next state and counter updates.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        lock_nxt  = lock_cnt;
        sel_cpu   = 1'b0;
        sel_aux   = 1'b0;
        stall     = 1'b0;
        case (state)
            S_CPU: begin
                wait_nxt = '0;
                if (cpu_act) begin
                    sel_cpu = 1'b1;
                    if (aux_req) begin
                        if (wait_cnt == STARVE_LAST) begin
                            state_nxt = S_FORCE;
                        end else begin
                            wait_nxt = wait_cnt + CNT_W'(1);
                        end
                    end
                end else if (aux_req) begin
                    sel_aux = 1'b1;
                    if (aux_lock && LOCK_ALLOWED) begin
                        state_nxt = S_LOCK;
                        lock_nxt  = CNT_W'(1);
                    end
                end
            end
            S_FORCE: begin
                sel_aux  = aux_req;
                stall    = cpu_act;
                wait_nxt = '0;
                if (aux_req && aux_lock && LOCK_ALLOWED) begin
                    state_nxt = S_LOCK;
                    lock_nxt  = CNT_W'(1);
                end else begin
                    state_nxt = S_CPU;
                end
            end
            S_LOCK: begin
                sel_aux  = aux_req;
                stall    = cpu_act;
                wait_nxt = '0;
                // lock_cnt counts grants already made; this grant reaching MAX_LOCK ends the burst.
                if (!aux_req || !aux_lock || (lock_cnt >= LOCK_LAST)) begin
                    state_nxt = S_CPU;
                    lock_nxt  = '0;
                end else begin
                    lock_nxt = lock_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_CPU;
                wait_nxt  = '0;
                lock_nxt  = '0;
            end
        endcase
    end

    // Bus and read-data steering; everything is held at 0 while in reset.
    always_comb begin
        bus_re    = 1'b0;
        bus_we    = 4'd0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        cpu_rdata = 32'd0;
        aux_rdata = 32'd0;
        aux_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (rst_n) begin
            cpu_stall = stall;
            if (sel_cpu) begin
                bus_re    = cpu_re;
                bus_we    = cpu_we;
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
                cpu_rdata = cpu_re ? bus_rdata : 32'd0;
            end else if (sel_aux) begin
                aux_gnt   = 1'b1;
                bus_re    = aux_rd;
                bus_we    = aux_we;
                bus_addr  = aux_addr;
                bus_wdata = aux_wdata;
                aux_rdata = aux_rd ? bus_rdata : 32'd0;
            end
        end
    end

`ifdef DATA_BUS_ARB_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] xfer_cnt;

    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (cpu_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (aux_gnt && (xfer_cnt != '1)) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end
        end
    end

    assign stat_cpu_stalls = stall_cnt;
    assign stat_aux_xfers  = xfer_cnt;
`else
    assign stat_cpu_stalls = 32'd0;
    assign stat_aux_xfers  = 32'd0;
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: the stimulus process evaluates an
// ownership model per cycle and queues the expected outputs; a monitor on the
// falling edge pops and compares against the DUT.
module tb_data_bus_arbiter;

    localparam int unsigned STARVE = 8;
    localparam int unsigned MAXL   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_re;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        aux_req, aux_lock;
    logic [3:0]  aux_we;
    logic [31:0] aux_addr, aux_wdata, aux_rdata;
    logic        aux_gnt;
    logic        bus_re;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [31:0] stat_cpu_stalls, stat_aux_xfers;

    always #5 clk = ~clk;

    data_bus_arbiter #(.STARVE_LIMIT(STARVE), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .aux_req(aux_req), .aux_lock(aux_lock), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata),
        .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .stat_cpu_stalls(stat_cpu_stalls), .stat_aux_xfers(stat_aux_xfers)
    );

    typedef struct {
        logic        bus_re;
        logic [3:0]  bus_we;
        logic [31:0] bus_addr;
        logic [31:0] bus_wdata;
        logic [31:0] cpu_rdata;
        logic        cpu_stall;
        logic        aux_gnt;
        logic [31:0] aux_rdata;
        logic        chk_stats;
        logic [31:0] st_stalls;
        logic [31:0] st_xfers;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   gnt_seen = 0;

    // Model: who owns the bus is "aux" while a forced slot or burst is pending.
    bit      m_force_slot;
    bit      m_in_burst;
    int      m_denied_run;
    int      m_burst_grants;
    longint  m_stalls;
    longint  m_xfers;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t aux_drive(input exp_t e);
        exp_t r = e;
        r.aux_gnt   = 1'b1;
        r.bus_re    = (aux_we == 4'd0);
        r.bus_we    = aux_we;
        r.bus_addr  = aux_addr;
        r.bus_wdata = aux_wdata;
        r.aux_rdata = (aux_we == 4'd0) ? bus_rdata : 32'd0;
        return r;
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'sh0FFFFFFFF) ? 32'hFFFFFFFF : 32'(v);
    endfunction

    // Evaluate the model for the inputs currently driven, queue expectation, advance a cycle.
    task automatic apply();
        exp_t e;
        bit   cact;
        e = '{default: '0};
        cact = cpu_re || (cpu_we != 4'd0);
`ifdef DATA_BUS_ARB_STATS_EN
        e.st_stalls = sat32(m_stalls);
        e.st_xfers  = sat32(m_xfers);
`endif
        e.chk_stats = rst_n;
        if (!rst_n) begin
            m_force_slot   = 1'b0;
            m_in_burst     = 1'b0;
            m_denied_run   = 0;
            m_burst_grants = 0;
            m_stalls       = 0;
            m_xfers        = 0;
        end else begin
            if (!(m_force_slot || m_in_burst)) begin
                if (cact) begin
                    e.bus_re    = cpu_re;
                    e.bus_we    = cpu_we;
                    e.bus_addr  = cpu_addr;
                    e.bus_wdata = cpu_wdata;
                    e.cpu_rdata = cpu_re ? bus_rdata : 32'd0;
                    if (aux_req) begin
                        m_denied_run++;
                        if (m_denied_run >= int'(STARVE)) begin
                            m_force_slot = 1'b1;
                            m_denied_run = 0;
                        end
                    end else begin
                        m_denied_run = 0;
                    end
                end else begin
                    m_denied_run = 0;
                    if (aux_req) begin
                        e = aux_drive(e);
                        if (aux_lock && MAXL > 1) begin
                            m_in_burst     = 1'b1;
                            m_burst_grants = 1;
                        end
                    end
                end
            end else begin
                e.cpu_stall = cact;
                if (aux_req) e = aux_drive(e);
                if (m_force_slot) begin
                    m_force_slot = 1'b0;
                    if (aux_req && aux_lock && MAXL > 1) begin
                        m_in_burst     = 1'b1;
                        m_burst_grants = 1;
                    end
                end else begin
                    if (aux_req) m_burst_grants++;
                    if (!aux_req || !aux_lock || m_burst_grants >= int'(MAXL)) begin
                        m_in_burst     = 1'b0;
                        m_burst_grants = 0;
                    end
                end
            end
            if (e.cpu_stall) m_stalls++;
            if (e.aux_gnt) m_xfers++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic all_idle();
        rst_n     = 1'b1;
        cpu_re    = 1'b0;
        cpu_we    = 4'd0;
        aux_req   = 1'b0;
        aux_lock  = 1'b0;
        aux_we    = 4'd0;
    endtask

    // Monitor: every falling edge carries one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bus_re",    32'(bus_re),    32'(e.bus_re));
            chk("bus_we",    32'(bus_we),    32'(e.bus_we));
            chk("bus_addr",  bus_addr,       e.bus_addr);
            chk("bus_wdata", bus_wdata,      e.bus_wdata);
            chk("cpu_rdata", cpu_rdata,      e.cpu_rdata);
            chk("cpu_stall", 32'(cpu_stall), 32'(e.cpu_stall));
            chk("aux_gnt",   32'(aux_gnt),   32'(e.aux_gnt));
            chk("aux_rdata", aux_rdata,      e.aux_rdata);
            if (e.chk_stats) begin
                chk("stat_cpu_stalls", stat_cpu_stalls, e.st_stalls);
                chk("stat_aux_xfers",  stat_aux_xfers,  e.st_xfers);
            end
            if (aux_gnt === 1'b1) gnt_seen++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        int kind;
        all_idle();
        rst_n     = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        aux_addr  = 32'd0;
        aux_wdata = 32'd0;
        bus_rdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        aux_req = 1'b1; cpu_re = 1'b1;
        apply();
        apply();

        // CPU-only read
        all_idle();
        cpu_re = 1'b1; cpu_addr = 32'h100; bus_rdata = 32'hDEADBEEF;
        apply();

        // Idle-slot aux write
        all_idle();
        aux_req = 1'b1; aux_we = 4'hF; aux_addr = 32'h200; aux_wdata = 32'h12345678;
        apply();
        all_idle();
        apply();

        // Starvation: exactly one aux grant in cycles 0..9
        all_idle();
        cpu_re = 1'b1; cpu_addr = 32'h300; aux_req = 1'b1; aux_addr = 32'h400;
        base = gnt_seen;
        for (int i = 0; i < 10; i++) begin
            bus_rdata = $urandom;
            apply();
        end
        chk("starve_grants", 32'(gnt_seen - base), 32'd1);
        all_idle();
        apply();

        // Lock limit: idle-slot lock start, CPU requesting from cycle 2
        all_idle();
        aux_req = 1'b1; aux_lock = 1'b1; aux_we = 4'h3; aux_addr = 32'h500;
        base = gnt_seen;
        apply();
        cpu_re = 1'b1;
        for (int i = 2; i <= 17; i++) begin
            aux_wdata = $urandom;
            apply();
        end
        chk("lock_grants", 32'(gnt_seen - base), 32'(MAXL));
        all_idle();
        apply();

        // Early release on the 3rd burst cycle
        all_idle();
        aux_req = 1'b1; aux_lock = 1'b1; aux_addr = 32'h600;
        base = gnt_seen;
        apply();
        cpu_we = 4'h1;
        apply();
        aux_lock = 1'b0;
        apply();
        apply();
        chk("release_grants", 32'(gnt_seen - base), 32'd3);
        all_idle();
        apply();

        // Reset on the 5th locked cycle
        all_idle();
        aux_req = 1'b1; aux_lock = 1'b1;
        apply();
        cpu_re = 1'b1;
        for (int i = 0; i < 3; i++) apply();
        rst_n = 1'b0;
        apply();
        rst_n = 1'b1;
        apply();
        apply();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            kind  = int'($urandom_range(0, 3));
            cpu_re = (kind == 1) || (kind == 3);
            cpu_we = (kind == 2) ? 4'($urandom_range(1, 15)) : 4'd0;
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            aux_req   = ($urandom_range(0, 9) < 6);
            aux_lock  = aux_lock ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 4);
            aux_we    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            aux_addr  = $urandom;
            aux_wdata = $urandom;
            bus_rdata = $urandom;
            apply();
        end

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
